// File: rtl/latealu_pkg.sv
// Shared definitions for the late-ALU stage: op codes, FSM encoding and helpers.
// The ALU stage imports the same op-code constants.
package latealu_pkg;

    localparam logic [5:0] LATEALU_OP_MULT  = 6'b000100;
    localparam logic [5:0] LATEALU_OP_MTHI  = 6'b000101;
    localparam logic [5:0] LATEALU_OP_MTLO  = 6'b000110;
    localparam logic [5:0] LATEALU_OP_MULTU = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } latealu_state_e;

    function automatic logic is_latealu_op(input logic [5:0] op);
        return (op == LATEALU_OP_MULT) || (op == LATEALU_OP_MULTU) ||
               (op == LATEALU_OP_MTHI) || (op == LATEALU_OP_MTLO);
    endfunction

    // 32-bit unsigned magnitude; 0x80000000 maps to 2^31 unchanged.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/latealu_mul_core.sv
// Iterative unsigned 32x32->64 shift-add multiplier retiring ITER_BITS
// multiplier bits per cycle; done is high during the final iteration cycle.
module latealu_mul_core #(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        done,
    output logic [63:0] product
);
    localparam int N_ITER = 32 / ITER_BITS;
    localparam int CNT_W  = $clog2(N_ITER);

    logic [63:0]      mcand_q, mcand_d;
    logic [31:0]      mplier_q, mplier_d;
    logic [63:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [63:0]      partial;

    always_comb begin
        // NOTE: every combinationally driven signal gets a default first so no latch is inferred.
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        partial  = '0;
        for (int i = 0; i < ITER_BITS; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
        if (start) begin
            mcand_d  = {32'd0, mcand};
            mplier_d = mplier;
            acc_d    = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << ITER_BITS;
            mplier_d = mplier_q >> ITER_BITS;
            cnt_d    = cnt_q + 1'b1;
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign done    = run_q && (cnt_q == CNT_W'(N_ITER - 1));
    assign product = acc_q;

endmodule

// File: rtl/pipeline_latealu.sv
// Late-ALU stage: owns HI/LO, runs mult/multu on the iterative core and
// executes mthi/mtlo in one cycle; commands arriving while busy are dropped.
module pipeline_latealu
    import latealu_pkg::*;
#(
    parameter int ITER_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        latealu_enable,
    input  logic [5:0]  latealu_op,
    input  logic [31:0] latealu_a0,
    input  logic [31:0] latealu_a1,
    output logic [31:0] latealu_mult_hi,
    output logic [31:0] latealu_mult_lo,
    output logic        latealu_busy,
    output logic        latealu_overrun
);
    latealu_state_e state_q, state_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic           neg_q, neg_d;
    logic           busy_q, busy_d;
    logic           overrun_q, overrun_d;
    logic           cmd, mul_start, mul_done;
    logic [31:0]    mul_a, mul_b;
    logic [63:0]    mul_product;

    latealu_mul_core #(.ITER_BITS(ITER_BITS)) u_mul_core (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .mcand   (mul_a),
        .mplier  (mul_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        cmd       = latealu_enable && is_latealu_op(latealu_op);
        overrun_d = cmd && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (cmd) begin
                    case (latealu_op)
                        LATEALU_OP_MTHI: hi_d = latealu_a0;
                        LATEALU_OP_MTLO: lo_d = latealu_a0;
                        LATEALU_OP_MULT: begin
                            mul_start = 1'b1;
                            mul_a     = mag32(latealu_a0);
                            mul_b     = mag32(latealu_a1);
                            neg_d     = latealu_a0[31] ^ latealu_a1[31];
                            state_d   = ST_MUL;
                        end
                        LATEALU_OP_MULTU: begin
                            mul_start = 1'b1;
                            mul_a     = latealu_a0;
                            mul_b     = latealu_a1;
                            neg_d     = 1'b0;
                            state_d   = ST_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: if (mul_done) state_d = ST_WB;
            ST_WB: begin
                {hi_d, lo_d} = neg_q ? (~mul_product + 64'd1) : mul_product;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign latealu_mult_hi = hi_q;
    assign latealu_mult_lo = lo_q;
    assign latealu_busy    = busy_q;
    assign latealu_overrun = overrun_q;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Self-checking bench: drives an ITER_BITS=1 and an ITER_BITS=4 instance in
// lockstep, with a table of multiply vectors and hand-written corner sequences.
module tb_pipeline_latealu;
    import latealu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [5:0]  op;
    logic [31:0] a0, a1;
    logic [31:0] hi1, lo1, hi4, lo4;
    logic        busy1, busy4, ovr1, ovr4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    pipeline_latealu #(.ITER_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .latealu_enable(en), .latealu_op(op),
        .latealu_a0(a0), .latealu_a1(a1), .latealu_mult_hi(hi1),
        .latealu_mult_lo(lo1), .latealu_busy(busy1), .latealu_overrun(ovr1)
    );

    pipeline_latealu #(.ITER_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .latealu_enable(en), .latealu_op(op),
        .latealu_a0(a0), .latealu_a1(a1), .latealu_mult_hi(hi4),
        .latealu_mult_lo(lo4), .latealu_busy(busy4), .latealu_overrun(ovr4)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [5:0] mop, input logic [31:0] x, input logic [31:0] y);
        if (mop == LATEALU_OP_MULT) return longint'($signed(x)) * longint'($signed(y));
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Present one command for exactly one edge; returns #1 after that edge.
    task automatic issue(input logic [5:0] cop, input logic [31:0] x, input logic [31:0] y);
        en = 1'b1; op = cop; a0 = x; a1 = y;
        tick();
        en = 1'b0; op = 6'd0; a0 = '0; a1 = '0;
    endtask

    // Count busy cycles on both instances (bounded) and compare against the scoreboard.
    task automatic wait_and_check(input int exp_lat1, input int exp_lat4, input logic [63:0] held);
        int   c1 = 0, c4 = 0, cyc = 0;
        logic hold1 = 1'b1, hold4 = 1'b1;
        exp_t e;
        while ((busy1 || busy4) && cyc < 100) begin
            if (busy1) begin c1++; if ({hi1, lo1} !== held) hold1 = 1'b0; end
            if (busy4) begin c4++; if ({hi4, lo4} !== held) hold4 = 1'b0; end
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (exp_lat1 >= 0) check({e.name, "_busy_cycles_i1"}, 64'(c1), 64'(exp_lat1));
        if (exp_lat4 >= 0) check({e.name, "_busy_cycles_i4"}, 64'(c4), 64'(exp_lat4));
        check({e.name, "_hold_i1"}, 64'(hold1), 64'd1);
        check({e.name, "_hold_i4"}, 64'(hold4), 64'd1);
        check({e.name, "_hilo_i1"}, {hi1, lo1}, {e.hi, e.lo});
        check({e.name, "_hilo_i4"}, {hi4, lo4}, {e.hi, e.lo});
    endtask

    initial begin
        logic [63:0] p, held;
        logic [31:0] x, y;
        exp_t        e;

        vecs[0] = '{"mult_7_m3",      LATEALU_OP_MULT,  32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{"multu_max",      LATEALU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"mult_min_min",   LATEALU_OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{"mult_min_1",     LATEALU_OP_MULT,  32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[4] = '{"multu_2p16",     LATEALU_OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[5] = '{"mult_m1_m1",     LATEALU_OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[6] = '{"mult_0_m1",      LATEALU_OP_MULT,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};

        rst = 1'b1; en = 1'b0; op = '0; a0 = '0; a1 = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_hilo_i1", {hi1, lo1}, 64'd0);
        check("reset_hilo_i4", {hi4, lo4}, 64'd0);
        check("reset_busy_ovr", {62'd0, busy1 | busy4, ovr1 | ovr4}, 64'd0);

        // Back-to-back mthi / mtlo.
        issue(LATEALU_OP_MTHI, 32'h12345678, 32'hFFFFFFFF);
        check("mthi_hi", 64'(hi1), 64'h12345678);
        check("mthi_lo_unchanged", 64'(lo1), 64'd0);
        check("mthi_busy", 64'(busy1 | busy4), 64'd0);
        issue(LATEALU_OP_MTLO, 32'h9ABCDEF0, 32'h0);
        check("mtlo_hilo_i1", {hi1, lo1}, 64'h12345678_9ABCDEF0);
        check("mtlo_hilo_i4", {hi4, lo4}, 64'h12345678_9ABCDEF0);
        check("mtlo_busy", 64'(busy1 | busy4), 64'd0);

        // Reserved op while idle: nothing happens.
        issue(6'b000000, 32'hDEAD, 32'hBEEF);
        check("reserved_idle_busy_ovr", {62'd0, busy1 | busy4, ovr1 | ovr4}, 64'd0);
        check("reserved_idle_hilo", {hi1, lo1}, 64'h12345678_9ABCDEF0);

        // Table-driven multiply vectors.
        for (int i = 0; i < 7; i++) begin
            held = {hi1, lo1};
            sb.push_back('{vecs[i].name, vecs[i].hi, vecs[i].lo});
            issue(vecs[i].op, vecs[i].a0, vecs[i].a1);
            wait_and_check(33, 9, held);
        end

        // Random vectors against the arithmetic model.
        for (int i = 0; i < 4; i++) begin
            x = $urandom(); y = $urandom();
            p = model((i % 2) ? LATEALU_OP_MULTU : LATEALU_OP_MULT, x, y);
            held = {hi1, lo1};
            sb.push_back('{$sformatf("rand%0d", i), p[63:32], p[31:0]});
            issue((i % 2) ? LATEALU_OP_MULTU : LATEALU_OP_MULT, x, y);
            wait_and_check(33, 9, held);
        end

        // mtlo during MUL: dropped, overrun pulses for one cycle.
        p = model(LATEALU_OP_MULT, 32'h00001234, 32'hFFFF5678);
        held = {hi1, lo1};
        sb.push_back('{"overrun_mult", p[63:32], p[31:0]});
        issue(LATEALU_OP_MULT, 32'h00001234, 32'hFFFF5678);
        tick(); tick();
        issue(LATEALU_OP_MTLO, 32'd5, 32'd0);
        check("overrun_pulse", {62'd0, ovr1, ovr4}, 64'h3);
        tick();
        check("overrun_cleared", {62'd0, ovr1, ovr4}, 64'h0);
        wait_and_check(-1, -1, held);

        // Reserved op while busy: no overrun.
        held = {hi1, lo1};
        issue(LATEALU_OP_MULT, 32'd3, 32'd5);
        issue(6'b111111, 32'd1, 32'd1);
        check("reserved_busy_no_ovr", {62'd0, ovr1, ovr4}, 64'h0);
        check("reserved_busy_still_busy", {62'd0, busy1, busy4}, 64'h3);

        // Reset at iteration 10 (edge E10): no partial commit, all cleared.
        for (int i = 2; i < 10; i++) tick();
        check("prereset_busy_i1", 64'(busy1), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_hilo_i1", {hi1, lo1}, 64'd0);
        check("midreset_hilo_i4", {hi4, lo4}, 64'd0);
        check("midreset_busy_ovr", {62'd0, busy1 | busy4, ovr1 | ovr4}, 64'd0);
        for (int i = 0; i < 40; i++) tick();
        check("postreset_quiet", {hi1, lo1, 31'd0, busy1}, 96'd0);

        // Accept right after busy falls.
        e = '{"after_reset", 32'h00000000, 32'h00000006};
        sb.push_back(e);
        issue(LATEALU_OP_MULTU, 32'd2, 32'd3);
        wait_and_check(33, 9, 64'd0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
